l1_dcache: RTL and testbench
============================

Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 cache between the pipeline's MEM-stage data port (dmem_*) and the shared physical-memory line port (pmem_*).
- A hit completes in the request cycle, so the EXMEM/MEMWB stall logic sees no added latency.
- A miss writes back the victim line if dirty, then fetches the new 256-bit line. During this time mem_resp stays low and the pipeline stalls.
- The same block can serve the instruction port with mem_write tied low.

Parameters:
- S_INDEX, 4, index bits; number of sets = 2**S_INDEX.
- S_OFFSET, 5, byte-offset bits; line = 256 bits, fixed.
- S_TAG, 32-S_INDEX-S_OFFSET, tag width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  32  word-aligned address; bits [1:0] are always 0
- mem_wdata  in  32  store data, already lane-positioned
- mem_byte_enable  in  4  store byte lanes
- mem_rdata  out  32  full aligned word
- mem_resp  out  1  request complete this cycle
- pmem_read  out  1  line fetch request
- pmem_write  out  1  line writeback request
- pmem_address  out  32  32-byte-aligned line address; bits [4:0] = 0
- pmem_wdata  out  256  victim line
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  line transfer complete, one-cycle pulse

Behaviour:
- Storage arrays, per set:
  - valid[1], dirty[1], tag[S_TAG], data[256]. All are flops.
  - On reset, valid and dirty clear to 0. Tag and data contents are don't-care.
- Address split:
  - tag = addr[31:S_INDEX+S_OFFSET]
  - idx = addr[S_INDEX+S_OFFSET-1:S_OFFSET]
  - word = addr[4:2]
- hit = valid[idx] && tag[idx]==tag(mem_address).
- Output reset values: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_rdata=0. State resets to IDLE.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - With no request, all outputs are 0 and the state is held.
  - Read hit: mem_resp=1 combinationally in the same cycle; mem_rdata = data[idx][word*32 +: 32].
  - Write hit: mem_resp=1 in the same cycle.
    - At the clock edge, each byte lane i with mem_byte_enable[i] set is written into the selected word.
    - dirty[idx] is set to 1.
  - Miss: the FSM latches miss_tag, miss_idx and the victim tag.
    - If valid && dirty, go to WRITEBACK.
    - Otherwise go to ALLOCATE.
    - mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim_tag, miss_idx, 5'b0}, pmem_wdata=data[miss_idx].
  - On pmem_resp, clear dirty[miss_idx] and go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={miss_tag, miss_idx, 5'b0}.
  - On pmem_resp, write data[miss_idx]=pmem_rdata, tag=miss_tag, valid=1, dirty=0, then go to IDLE.
  - The request then hits on the next cycle: miss latency = pmem latency + 1 cycle.
- pmem_read and pmem_write are never both 1. Each is held stable, including pmem_address, until pmem_resp.
- pmem_resp while in IDLE is ignored.
- If mem_read and mem_write are both 1, the request is treated as a write. A simulation-only assertion flags it.
- If the request is withdrawn or changes address mid-miss, the latched transfer completes and the FSM returns to IDLE. The new request is then evaluated fresh; no corruption.
- Byte enable of 0 on a write hit: mem_resp=1, data unchanged, dirty still set.
- Reset asserted mid-miss:
  - pmem_read/pmem_write drop immediately (asynchronously); state goes to IDLE and all lines are invalidated.
  - Dirty data is discarded.
  - The memory model must tolerate an aborted request.

Decomposition:
- Package cache_types holds:
  - the cache_state_t enum (IDLE, WRITEBACK, ALLOCATE)
  - localparams for line width (256), word count (8), and the S_INDEX/S_OFFSET defaults
- Sub-module cache_datapath holds:
  - the valid/dirty/tag/data arrays and address slicing
  - hit compare and byte-enable merge
  - pmem_address mux
- The top level holds only the FSM (control) and wiring.

Test Plan:
- Cold read: after reset, read 0x0000_1004 with memory line word1=0xDEAD_BEEF -> pmem_read=1 with pmem_address=0x0000_1000 until pmem_resp; next cycle mem_resp=1, mem_rdata=0xDEAD_BEEF.
- Write hit then read: write 0x0000_1004 data 0x1122_3344 byte_enable 4'b0110 onto 0xDEAD_BEEF -> same-cycle mem_resp; a following read returns 0xDE22_33EF with no pmem activity.
- Dirty eviction: after the previous step, read conflicting address 0x0000_1204 (same idx, new tag) -> pmem_write at 0x0000_1000 with word1=0xDE22_33EF, then pmem_read at 0x0000_1200, then mem_resp.
- Clean eviction: read 0x0000_2000, then conflicting read 0x0000_2200 -> no pmem_write; a single pmem_read at 0x0000_2200.
- Back-to-back hits: 8 consecutive reads of words 0x1000..0x101C -> mem_resp=1 every cycle, correct word per offset.
- Reset during ALLOCATE with pmem_resp withheld -> pmem_read=0 in the same cycle as rst; after release, a read of the same address misses again.

Source files
------------

// File: rtl/l1_dcache_pkg.sv
// Shared types and sizing constants for the L1 data cache.
// The line geometry is fixed at 256 bits, which is 8 words.
package cache_types;

    localparam int LINE_W       = 256;
    localparam int WORDS        = 8;
    localparam int DEF_S_INDEX  = 4;
    localparam int DEF_S_OFFSET = 5;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

    // Selects which line address the datapath presents on pmem_address.
    typedef enum logic [1:0] {
        PADDR_NONE,
        PADDR_VICTIM,
        PADDR_MISS
    } paddr_sel_t;

endpackage

// File: rtl/l1_dcache_datapath.sv
// Holds the valid, dirty, tag and data arrays, and the miss/victim latches.
// Also holds the hit compare, the store byte merge and the pmem address mux.
module cache_datapath
    import cache_types::*;
#(
    parameter int S_INDEX  = DEF_S_INDEX,
    parameter int S_OFFSET = DEF_S_OFFSET,
    localparam int S_TAG   = 32 - S_INDEX - S_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_byte_enable,
    input  logic              write_hit,
    input  logic              load_miss,
    input  logic              clear_dirty,
    input  logic              fill,
    input  paddr_sel_t        paddr_sel,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              hit,
    output logic              victim_dirty,
    output logic [31:0]       hit_word,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] victim_line
);

    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [S_TAG-1:0]   tag_q  [SETS];
    logic [LINE_W-1:0]  data_q [SETS];

    logic [S_TAG-1:0]   miss_tag_q;
    logic [S_TAG-1:0]   victim_tag_q;
    logic [S_INDEX-1:0] miss_idx_q;

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [2:0]         req_word;
    logic [LINE_W-1:0]  merged_line;
    logic               unused_addr_bits;

    assign req_tag          = mem_address[31:S_INDEX+S_OFFSET];
    assign req_idx          = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign req_word         = mem_address[4:2];
    assign unused_addr_bits = ^mem_address[1:0];

    assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
    assign hit_word     = data_q[req_idx][{req_word, 5'b0} +: 32];
    assign victim_line  = (paddr_sel == PADDR_VICTIM) ? data_q[miss_idx_q] : '0;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        merged_line = data_q[req_idx];
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                merged_line[{req_word, b[1:0], 3'b0} +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        case (paddr_sel)
            PADDR_VICTIM: pmem_address = {victim_tag_q, miss_idx_q, {S_OFFSET{1'b0}}};
            PADDR_MISS:   pmem_address = {miss_tag_q, miss_idx_q, {S_OFFSET{1'b0}}};
            default:      pmem_address = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_tag_q   <= '0;
            victim_tag_q <= '0;
            miss_idx_q   <= '0;
        end else begin
            if (load_miss) begin
                miss_tag_q   <= req_tag;
                miss_idx_q   <= req_idx;
                victim_tag_q <= tag_q[req_idx];
            end
            if (write_hit)   dirty_q[req_idx]    <= 1'b1;
            if (clear_dirty) dirty_q[miss_idx_q] <= 1'b0;
            if (fill) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; valid_q gates every use of them.
    always_ff @(posedge clk) begin
        if (write_hit) data_q[req_idx] <= merged_line;
        if (fill) begin
            data_q[miss_idx_q] <= pmem_rdata;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 cache: control FSM and wiring.
// A hit responds combinationally. A miss optionally writes back the dirty victim, then fills the line.
module l1_dcache
    import cache_types::*;
#(
    parameter int S_INDEX  = DEF_S_INDEX,
    parameter int S_OFFSET = DEF_S_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_byte_enable,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    cache_state_t state_q, state_d;
    paddr_sel_t   paddr_sel;
    logic         req, hit, victim_dirty;
    logic         write_hit, load_miss, clear_dirty, fill;
    logic [31:0]  hit_word;

    assign req = mem_read || mem_write;

    cache_datapath #(
        .S_INDEX  (S_INDEX),
        .S_OFFSET (S_OFFSET)
    ) u_datapath (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .write_hit       (write_hit),
        .load_miss       (load_miss),
        .clear_dirty     (clear_dirty),
        .fill            (fill),
        .paddr_sel       (paddr_sel),
        .pmem_rdata      (pmem_rdata),
        .hit             (hit),
        .victim_dirty    (victim_dirty),
        .hit_word        (hit_word),
        .pmem_address    (pmem_address),
        .victim_line     (pmem_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req && !hit) state_d = victim_dirty ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (pmem_resp)   state_d = ALLOCATE;
            ALLOCATE:  if (pmem_resp)   state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // A simultaneous read and write is served as a write, so rdata stays 0 in that case.
    always_comb begin
        mem_resp    = 1'b0;
        mem_rdata   = '0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        paddr_sel   = PADDR_NONE;
        write_hit   = 1'b0;
        load_miss   = 1'b0;
        clear_dirty = 1'b0;
        fill        = 1'b0;
        case (state_q)
            IDLE: begin
                mem_resp  = req && hit;
                write_hit = mem_write && hit;
                load_miss = req && !hit;
                if (mem_read && !mem_write && hit) mem_rdata = hit_word;
            end
            WRITEBACK: begin
                pmem_write  = 1'b1;
                paddr_sel   = PADDR_VICTIM;
                clear_dirty = pmem_resp;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                paddr_sel = PADDR_MISS;
                fill      = pmem_resp;
            end
            default: ;
        endcase
    end

    read_write_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_l1_dcache.sv
// Randomized bench for l1_dcache against a flat-memory golden model plus a set-occupancy model.
// A pmem responder with random latency backs the cache and checks every writeback line.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address, mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    l1_dcache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the memory as the CPU should see it, plus which line each set holds.
    bit           m_valid [16];
    bit           m_dirty [16];
    int unsigned  m_tag   [16];
    logic [31:0]  golden     [bit [31:0]];
    logic [255:0] pmem_store [bit [31:0]];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
    } xfer_t;
    xfer_t xlog[$];

    bit          hold_resp = 1'b0;
    logic [31:0] last_rdata;

    function automatic logic [31:0] init_word(bit [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [255:0] store_line(bit [31:0] la);
        logic [255:0] l;
        if (pmem_store.exists(la)) return pmem_store[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] get_golden(bit [31:0] a);
        logic [255:0] l;
        int w;
        if (golden.exists(a)) return golden[a];
        l = store_line(a & ~32'd31);
        w = int'((a >> 2) & 7);
        return l[w*32 +: 32];
    endfunction

    function automatic logic [255:0] golden_line(bit [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = get_golden(la + 32'(w * 4));
        return l;
    endfunction

    // Physical memory: random latency, tolerates aborted requests, checks hold and exclusivity.
    initial begin
        bit          busy = 1'b0;
        bit          req_wr;
        logic [31:0] req_addr;
        int          lat;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (rst || !(pmem_read || pmem_write)) begin
                busy = 1'b0;
                continue;
            end
            check("pmem_rw_exclusive", pmem_read && pmem_write, 1'b0);
            if (!busy) begin
                busy     = 1'b1;
                req_wr   = pmem_write;
                req_addr = pmem_address;
                lat      = int'($urandom_range(1, 4));
            end else begin
                check("pmem_addr_stable", pmem_address, req_addr);
                check("pmem_kind_stable", pmem_write, req_wr);
            end
            if (hold_resp) continue;
            lat--;
            if (lat == 0) begin
                if (req_wr) begin
                    check("wb_data", pmem_wdata, golden_line(req_addr));
                    pmem_store[req_addr] = pmem_wdata;
                end else begin
                    pmem_rdata = store_line(req_addr);
                end
                pmem_resp = 1'b1;
                xlog.push_back('{wr: req_wr, addr: req_addr});
                busy = 1'b0;
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int unsigned idx    = (a >> 5) & 15;
        int unsigned tag    = a >> 9;
        bit          exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        bit          exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
        logic [31:0] vaddr   = (m_tag[idx] << 9) | (idx << 5);
        int          n_exp   = exp_hit ? 0 : (exp_wb ? 2 : 1);
        int          cycles  = 0;
        int          k       = 0;
        logic [31:0] w;
        xlog.delete();
        @(negedge clk);
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = a;
        mem_wdata       = wd;
        mem_byte_enable = be;
        #1;
        while (!mem_resp && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check("mem_resp", mem_resp, 1'b1);
        last_rdata = mem_rdata;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check("hit_same_cycle", cycles == 0, exp_hit);
        check("pmem_xfers", xlog.size(), n_exp);
        if (!exp_hit && xlog.size() == n_exp) begin
            if (exp_wb) begin
                check("wb_kind", xlog[0].wr, 1'b1);
                check("wb_addr", xlog[0].addr, vaddr);
                k = 1;
            end
            check("fill_kind", xlog[k].wr, 1'b0);
            check("fill_addr", xlog[k].addr, a & ~32'd31);
        end
        if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            w = get_golden(a);
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            golden[a]    = w;
            m_dirty[idx] = 1'b1;
        end else begin
            check("rdata", last_rdata, get_golden(a));
        end
    endtask

    initial begin
        logic [255:0] seed_line;
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
        seed_line             = store_line(32'h0000_1000);
        seed_line[32 +: 32]   = 32'hDEAD_BEEF;
        pmem_store[32'h1000]  = seed_line;

        #12;
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_pmem_wdata", pmem_wdata, 256'h0);
        @(negedge clk);
        rst = 1'b0;

        do_req(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        check("cold_read_word", last_rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 32'h0000_1004, 32'h1122_3344, 4'b0110);
        do_req(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        check("merged_word", last_rdata, 32'hDE22_33EF);
        do_req(1'b0, 32'h0000_1204, 32'h0, 4'h0);
        check("evicted_word_stored", pmem_store[32'h1000][63:32], 32'hDE22_33EF);
        do_req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        do_req(1'b0, 32'h0000_2200, 32'h0, 4'h0);

        do_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) do_req(1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, 4'h0);

        // Abort a fill with reset while memory is holding off its response.
        @(negedge clk);
        hold_resp   = 1'b1;
        mem_read    = 1'b1;
        mem_address = 32'h0000_3000;
        repeat (3) @(negedge clk);
        #1;
        check("abort_pmem_read_before", pmem_read, 1'b1);
        check("abort_pmem_addr_before", pmem_address, 32'h0000_3000);
        #1;
        rst = 1'b1;
        #1;
        check("abort_pmem_read", pmem_read, 1'b0);
        check("abort_pmem_write", pmem_write, 1'b0);
        check("abort_mem_resp", mem_resp, 1'b0);
        @(negedge clk);
        mem_read  = 1'b0;
        rst       = 1'b0;
        hold_resp = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        golden.delete();
        do_req(1'b0, 32'h0000_3000, 32'h0, 4'h0);

        do_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        do_req(1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'b0000);
        do_req(1'b0, 32'h0000_1008, 32'h0, 4'h0);
        do_req(1'b0, 32'h0000_1208, 32'h0, 4'h0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(16, 19)) << 9) | (32'($urandom_range(0, 15)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 1) == 1) do_req(1'b1, a, $urandom, 4'($urandom_range(0, 15)));
            else                           do_req(1'b0, a, 32'h0, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
